// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard control for the ID/EX buffer, driven off a falling-edge shadow pipe.
// Optional performance counters are compiled in with `define FWD_HAZARD_PERF_EN.
module fwd_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             flush,
  input  logic             mem_busy,
  output logic             fwd_ex_1,
  output logic             fwd_mem_1,
  output logic             fwd_ex_2,
  output logic             fwd_mem_2,
  output logic             clear,
  output logic             stall
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_fwd_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } ex_slot_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wr;
  } mem_slot_t;

  ex_slot_t  ex_q;
  mem_slot_t mem_q;

  logic match_ex_1, match_ex_2, match_mem_1, match_mem_2;
  logic lu;
  logic stall_c, clear_c;

  // Register x0 is hard-wired, so a write to it never produces a forwardable value.
  assign match_ex_1  = id_valid & id_use_rs1 & (id_rs1 != '0) & ex_q.v  & ex_q.wr  & (ex_q.rd  == id_rs1);
  assign match_ex_2  = id_valid & id_use_rs2 & (id_rs2 != '0) & ex_q.v  & ex_q.wr  & (ex_q.rd  == id_rs2);
  assign match_mem_1 = id_valid & id_use_rs1 & (id_rs1 != '0) & mem_q.v & mem_q.wr & (mem_q.rd == id_rs1);
  assign match_mem_2 = id_valid & id_use_rs2 & (id_rs2 != '0) & mem_q.v & mem_q.wr & (mem_q.rd == id_rs2);

  assign lu = (match_ex_1 | match_ex_2) & ex_q.ld;

  always_comb begin
    stall_c = 1'b0;
    clear_c = 1'b0;
    if (mem_busy) begin
      stall_c = 1'b1;
    end else if (flush) begin
      clear_c = 1'b1;
    end else if (lu) begin
      stall_c = 1'b1;
      clear_c = 1'b1;
    end
  end

  // Outputs are forced low for as long as reset is held, independent of the clock.
  assign fwd_ex_1  = rst & match_ex_1 & ~ex_q.ld;
  assign fwd_ex_2  = rst & match_ex_2 & ~ex_q.ld;
  assign fwd_mem_1 = rst & match_mem_1 & ~match_ex_1;
  assign fwd_mem_2 = rst & match_mem_2 & ~match_ex_2;
  assign stall     = rst & stall_c;
  assign clear     = rst & clear_c;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else if (!mem_busy) begin
      mem_q <= '{v: ex_q.v, rd: ex_q.rd, wr: ex_q.wr};
      if (clear_c) begin
        ex_q <= '0;
      end else begin
        ex_q <= '{v: id_valid, rd: id_rd, wr: id_RegWrite, ld: id_MemRead};
      end
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic any_fwd;
  assign any_fwd = match_ex_1 & ~ex_q.ld | match_ex_2 & ~ex_q.ld | fwd_mem_1 | fwd_mem_2;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
      perf_flush_cnt <= '0;
    end else if (!mem_busy) begin
      if (!flush && lu && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (any_fwd && perf_fwd_cnt != '1)        perf_fwd_cnt   <= perf_fwd_cnt + 1'b1;
      if (flush && perf_flush_cnt != '1)        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule
